branch_ctrl: RTL and testbench

- Control-side counterpart of the program counter. It sequences program execution and drives the PC's Start, BranchEn, ZeroFlag and Target inputs.
- It holds the run/halt state machine, the registered zero flag captured from the ALU, a branch-target lookup table indexed by the branch instruction's short field, and a run-cycle counter.
- It sits between decode/ALU and the PC. All outputs are timed so the PC acts on them at the next rising Clk edge.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_lut.sv | 45 ++++
 rtl/branch_ctrl.sv | 104 ++++++++++
 tb/tb_branch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch controller slice.
//   state_t          - run/halt FSM state encoding (IDLE, RUN, DONE)
//   A_DEF, L_DEF     - default address width and LUT index width
//   BR_DEFAULT_TABLE - reset/default contents of the branch-target LUT
//   br_default()     - table lookup helper; indices past the table read 0
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned A_DEF       = 10;
  localparam int unsigned L_DEF       = 4;
  localparam int unsigned DEF_DEPTH   = 2**L_DEF;

  localparam logic [A_DEF-1:0] BR_DEFAULT_TABLE [DEF_DEPTH] = '{
    10'h000, 10'h010, 10'h020, 10'h02A,
    10'h040, 10'h050, 10'h060, 10'h070,
    10'h080, 10'h090, 10'h0A0, 10'h0B0,
    10'h0C0, 10'h0D0, 10'h0E0, 10'h0F0
  };

  function automatic logic [A_DEF-1:0] br_default(input int unsigned idx);
    if (idx < DEF_DEPTH) return BR_DEFAULT_TABLE[idx[L_DEF-1:0]];
    else                 return '0;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// branch_lut: branch-target lookup table, combinational read.
//   Clk, Reset          - clock, synchronous active-high reset
//   we, waddr, wdata    - write port (used only with BRANCH_LUT_WR_EN)
//   raddr, rdata        - combinational read port
// Macro BRANCH_LUT_WR_EN: when defined the LUT is a writable register array
// reset to the default table; otherwise it is the constant default table.
// A same-cycle write to the read index returns the old entry.
module branch_lut
  import branch_pkg::*;
#(
  parameter int unsigned A = 10,
  parameter int unsigned L = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         we,
  input  logic [L-1:0] waddr,
  input  logic [A-1:0] wdata,
  input  logic [L-1:0] raddr,
  output logic [A-1:0] rdata
);

  localparam int unsigned DEPTH = 2**L;

`ifdef BRANCH_LUT_WR_EN
  logic [A-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i[L-1:0]] <= A'(br_default(i));
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb rdata = mem[raddr];
`else
  logic unused_wr;
  assign unused_wr = ^{Clk, Reset, we, waddr, wdata};

  always_comb rdata = A'(br_default(32'(raddr)));
`endif

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: run/halt sequencer driving the program counter.
//   Clk, Reset   - clock, synchronous active-high reset
//   Req          - program request (level)
//   HaltInstr    - halt decoded at current PC
//   BrInstr      - conditional branch decoded at current PC
//   BrIdx        - branch LUT index
//   FlagWe       - instruction updates the zero flag
//   AluZero      - ALU zero result
//   LutWe/LutWaddr/LutWdata - LUT write port (BRANCH_LUT_WR_EN only)
//   Start        - PC advance enable
//   BranchEn     - branch request to PC
//   ZeroFlag     - registered zero flag
//   Target       - branch target = LUT[BrIdx]
//   Done         - program halted (registered)
//   CycleCnt     - saturating count of cycles spent in RUN
// Optional macro BRANCH_LUT_WR_EN (handled inside branch_lut) makes the LUT writable.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned A  = A_DEF,
  parameter int unsigned L  = L_DEF,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req,
  input  logic          HaltInstr,
  input  logic          BrInstr,
  input  logic [L-1:0]  BrIdx,
  input  logic          FlagWe,
  input  logic          AluZero,
  input  logic          LutWe,
  input  logic [L-1:0]  LutWaddr,
  input  logic [A-1:0]  LutWdata,
  output logic          Start,
  output logic          BranchEn,
  output logic          ZeroFlag,
  output logic [A-1:0]  Target,
  output logic          Done,
  output logic [CW-1:0] CycleCnt
);

  state_t        state;
  logic          zero_q;
  logic          done_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      zero_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            state <= RUN;
            cnt_q <= '0;
          end
        end
        RUN: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (FlagWe) zero_q <= AluZero;
          if (HaltInstr) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (!Req) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Halt has priority over a branch decoded in the same cycle.
  always_comb begin
    Start    = (state == RUN) & ~HaltInstr;
    BranchEn = (state == RUN) & BrInstr & ~HaltInstr;
  end

  assign ZeroFlag = zero_q;
  assign Done     = done_q;
  assign CycleCnt = cnt_q;

  branch_lut #(
    .A(A),
    .L(L)
  ) u_lut (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (LutWe),
    .waddr (LutWaddr),
    .wdata (LutWdata),
    .raddr (BrIdx),
    .rdata (Target)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  localparam logic [9:0] TB_DEF [16] = '{
    10'h000, 10'h010, 10'h020, 10'h02A, 10'h040, 10'h050, 10'h060, 10'h070,
    10'h080, 10'h090, 10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 10'h0E0, 10'h0F0
  };

  logic       Clk = 1'b0;
  logic       rst, req, halt, br, fwe, az, lwe;
  logic [3:0] idx, lwa;
  logic [9:0] lwd;

  logic        Start, BranchEn, ZeroFlag, Done;
  logic [9:0]  Target;
  logic [15:0] CycleCnt;
  logic        s_start, s_bren, s_zero, s_done;
  logic [9:0]  s_target;
  logic [2:0]  s_cnt;

  always #5 Clk = ~Clk;

  branch_ctrl #(.A(10), .L(4), .CW(16)) dut (
    .Clk(Clk), .Reset(rst), .Req(req), .HaltInstr(halt), .BrInstr(br),
    .BrIdx(idx), .FlagWe(fwe), .AluZero(az), .LutWe(lwe), .LutWaddr(lwa),
    .LutWdata(lwd), .Start(Start), .BranchEn(BranchEn), .ZeroFlag(ZeroFlag),
    .Target(Target), .Done(Done), .CycleCnt(CycleCnt)
  );

  branch_ctrl #(.A(10), .L(4), .CW(3)) dut_sat (
    .Clk(Clk), .Reset(rst), .Req(req), .HaltInstr(halt), .BrInstr(br),
    .BrIdx(idx), .FlagWe(fwe), .AluZero(az), .LutWe(lwe), .LutWaddr(lwa),
    .LutWdata(lwd), .Start(s_start), .BranchEn(s_bren), .ZeroFlag(s_zero),
    .Target(s_target), .Done(s_done), .CycleCnt(s_cnt)
  );

  typedef struct {
    logic        start, bren, zero, done;
    logic [9:0]  target;
    logic [15:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model
  int          m_st;
  logic        m_zero, m_done;
  logic [15:0] m_cnt;
  logic [2:0]  m_sat;
  logic [9:0]  m_lut [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_zero = 1'b0; m_done = 1'b0; m_cnt = '0; m_sat = '0;
    for (int i = 0; i < 16; i++) m_lut[i] = TB_DEF[i];
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
`ifdef BRANCH_LUT_WR_EN
      if (lwe) m_lut[lwa] = lwd;
`endif
      case (m_st)
        S_IDLE: if (req) begin m_st = S_RUN; m_cnt = '0; m_sat = '0; end
        S_RUN: begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_sat != 3'd7) m_sat = m_sat + 3'd1;
          if (fwe) m_zero = az;
          if (halt) begin m_st = S_DONE; m_done = 1'b1; end
        end
        default: if (!req) begin m_st = S_IDLE; m_done = 1'b0; end
      endcase
    end
  endtask

  // One clock cycle: push expectation for the current inputs, compare at the
  // falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    exp_t e, p;
    e.start  = (m_st == S_RUN) && !halt;
    e.bren   = (m_st == S_RUN) && br && !halt;
    e.zero   = m_zero;
    e.done   = m_done;
    e.target = m_lut[idx];
    e.cnt    = m_cnt;
    e.sat    = m_sat;
    q.push_back(e);
    @(negedge Clk);
    p = q.pop_front();
    chk("start",  32'(Start),    32'(p.start));
    chk("bren",   32'(BranchEn), 32'(p.bren));
    chk("zero",   32'(ZeroFlag), 32'(p.zero));
    chk("done",   32'(Done),     32'(p.done));
    chk("target", 32'(Target),   32'(p.target));
    chk("cnt",    32'(CycleCnt), 32'(p.cnt));
    chk("satcnt", 32'(s_cnt),    32'(p.sat));
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; halt = 1'b0; br = 1'b0; fwe = 1'b0; az = 1'b0;
    lwe = 1'b0; lwa = '0; lwd = '0; idx = 4'd3;
    @(posedge Clk); #1;
    model_reset();
    step();
    chk("rst_target", 32'(Target), 32'h02A);
    chk("rst_cnt", 32'(CycleCnt), 0);

    // basic run: 1 request cycle, 5 run cycles, halt
    rst = 1'b0; req = 1'b1; step();
    req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    halt = 1'b1; #1; chk("halt_start", 32'(Start), 0); step();
    halt = 1'b0;
    chk("halt_done", 32'(Done), 1);
    chk("halt_cnt6", 32'(CycleCnt), 6);

    // DONE holds while Req stays high, returns to IDLE on Req low
    req = 1'b1; step(); step();
    chk("done_hold", 32'(Done), 1);
    req = 1'b0; step();
    chk("idle_done0", 32'(Done), 0);
    req = 1'b1; step();
    req = 1'b0;
    chk("rerun_cnt0", 32'(CycleCnt), 0);

    // branch taken with zero flag set, then with flag cleared
    fwe = 1'b1; az = 1'b1; step();
    fwe = 1'b0; br = 1'b1; idx = 4'd3; #1;
    chk("br_zero1", 32'(ZeroFlag), 1);
    chk("br_en", 32'(BranchEn), 1);
    chk("br_target", 32'(Target), 32'h02A);
    step();
    br = 1'b0; fwe = 1'b1; az = 1'b0; step();
    fwe = 1'b0; br = 1'b1; #1;
    chk("br_zero0", 32'(ZeroFlag), 0);
    step();

    // flag write and branch together: branch sees old flag
    fwe = 1'b1; az = 1'b1; #1;
    chk("haz_zero_old", 32'(ZeroFlag), 0);
    chk("haz_bren", 32'(BranchEn), 1);
    step();
    fwe = 1'b0; br = 1'b0;
    chk("haz_zero_new", 32'(ZeroFlag), 1);

    // halt and branch together: halt wins
    halt = 1'b1; br = 1'b1; #1;
    chk("hb_bren", 32'(BranchEn), 0);
    chk("hb_start", 32'(Start), 0);
    step();
    halt = 1'b0; br = 1'b0; step();

    // LUT write with same-index read
    idx = 4'd5; lwe = 1'b1; lwa = 4'd5; lwd = 10'h3FF; #1;
    chk("lut_old", 32'(Target), 32'h050);
    step();
    lwe = 1'b0; #1;
`ifdef BRANCH_LUT_WR_EN
    chk("lut_new", 32'(Target), 32'h3FF);
`else
    chk("lut_const", 32'(Target), 32'h050);
`endif
    step();

    // reset mid-run overrides halt, req and LUT write
    req = 1'b1; step();
    req = 1'b0; step(); step(); step();
    rst = 1'b1; halt = 1'b1; req = 1'b1; lwe = 1'b1; lwa = 4'd5; lwd = 10'h155;
    step();
    rst = 1'b0; halt = 1'b0; req = 1'b0; lwe = 1'b0; #1;
    chk("mrst_start", 32'(Start), 0);
    chk("mrst_done", 32'(Done), 0);
    chk("mrst_cnt", 32'(CycleCnt), 0);
    chk("mrst_lut", 32'(Target), 32'h050);
    step();

    // saturation of the 3-bit counter
    req = 1'b1; step();
    req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("sat7", 32'(s_cnt), 7);
    chk("cnt10", 32'(CycleCnt), 10);
    halt = 1'b1; step();
    halt = 1'b0; step();
    chk("sat_hold", 32'(s_cnt), 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
